text_grid_ctrl: RTL
===================

Name: text_grid_ctrl

Overview:
- Text-overlay controller that owns a ROWS x COLS character buffer and drives the per-pixel glyph renderer.
- Accepts a stream of ASCII bytes through a valid/ready handshake and runs a cursor, with wrap, newline and backspace.
- Clears the buffer on reset or on request.
- For every pixel position, returns the character code and cell origin that the glyph renderer draws at that pixel.

Parameters:
- COLS, 16, characters per text row.
- ROWS, 4, text rows.
- PITCH, 8, cell pitch in glyph units: 7 glyph pixels plus 1 gap. Multiplied by size to give screen pixels.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_valid  in  1  character byte offered
- wr_char  in  8  ASCII byte
- wr_ready  out  1  controller can accept a byte this cycle
- clear  in  1  one-cycle pulse: blank the buffer and home the cursor
- Hpos  in  12  current pixel column
- Vpos  in  12  current pixel row
- Hori  in  12  text-area left edge
- Vori  in  12  text-area top edge
- size  in  12  glyph pixel scale
- AsciiCode  out  8  character code at (Hpos,Vpos)
- CharHori  out  12  left edge of that character cell
- CharVori  out  12  top edge of that character cell
- busy  out  1  CLEAR or SCROLL in progress
- cur_col  out  $clog2(COLS)  cursor column
- cur_row  out  $clog2(ROWS)  cursor row

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values:
  - state=CLEAR, clear address=0.
  - cur_col=0, cur_row=0, wr_ready=0, busy=1.
  - AsciiCode=8'h20, CharHori=0, CharVori=0.
- FSM states: CLEAR, IDLE, SCROLL (SCROLL exists only with the optional feature).
- CLEAR:
  - Writes 8'h20 to one buffer address per cycle, 0 to ROWS*COLS-1.
  - Goes to IDLE the cycle after the last address. Total = ROWS*COLS cycles.
  - Cursor is forced to (0,0). wr_ready=0 and busy=1 throughout.
- IDLE:
  - wr_ready=1 and busy=0. A byte is accepted on wr_valid&&wr_ready.
  - 8'h20..8'h7E: written at (cur_row,cur_col), then cur_col+1.
  - Wrap: if cur_col reaches COLS, set cur_col=0 and cur_row+1. If cur_row passes ROWS-1, it wraps to 0.
  - 8'h0A: cur_col=0, cur_row+1, with the same row wrap.
  - 8'h08: if cur_col>0, cur_col-1 and write 8'h20 at the new position. At column 0 it has no effect.
  - Any other byte is accepted and discarded.
- clear:
  - Sampled in every state. clear in IDLE enters CLEAR next cycle.
  - clear during CLEAR or SCROLL restarts CLEAR from address 0.
  - If clear and a write handshake occur in the same cycle, clear wins and the byte is dropped, although it counts as accepted.
- Pixel lookup (separate read port, never stalls writes; 1-cycle registered latency):
  - dx=Hpos-Hori, dy=Vpos-Vori, cw=PITCH*size.
  - c=dx/cw, r=dy/cw.
  - Inside the area when Hpos>=Hori && Vpos>=Vori && size!=0 && c<COLS && r<ROWS.
  - Inside: next cycle AsciiCode=buf[r][c], CharHori=Hori+c*cw, CharVori=Vori+r*cw.
  - Outside: AsciiCode=8'h20, CharHori=Hori, CharVori=Vori.
  - Arithmetic is 12-bit unsigned. The subtraction is evaluated only when the >= guard holds.
- A buffer write and a lookup read of the same cell in the same cycle return the old contents.

Optional Feature:
- Macro: TEXT_GRID_SCROLL_EN.
- With the macro, when the row advance would pass ROWS-1 (via wrap or 8'h0A), the FSM enters SCROLL:
  - Copies row i+1 to row i, one byte per cycle, for COLS*(ROWS-1) cycles.
  - Then blanks the last row, COLS cycles.
  - Then returns to IDLE with cur_row=ROWS-1 and cur_col=0.
  - wr_ready=0 and busy=1 during SCROLL.
  - The lookup port may show the partially scrolled buffer.
- Without the macro, the row wraps to 0 and no SCROLL state exists.

Decomposition:
- Package text_grid_pkg holds:
  - state enum {CLEAR, IDLE, SCROLL}
  - constants CH_SPACE=8'h20, CH_LF=8'h0A, CH_BS=8'h08, CH_PRINT_LO=8'h20, CH_PRINT_HI=8'h7E.
- One natural sub-module: text_grid_ram.
  - ROWS*COLS x 8, one synchronous write port, one synchronous read port.

Test Plan:
- Reset then wait: wr_ready stays 0 for 64 cycles (16x4), rises on cycle 65. Every cell reads 8'h20 and busy=0.
- Write "HI" with Hori=Vori=100, size=2. Pixel (100,100) gives AsciiCode=8'h48 with CharHori=100, CharVori=100. Pixel (117,103) gives 8'h49, CharHori=116, CharVori=100, one cycle later.
- 17 'A' bytes: cursor ends at (1,1). Byte 8'h0A then gives (2,0). Byte 8'h08 at column 0 changes nothing.
- Pixel (99,100), pixel at column 16, or size=0: AsciiCode=8'h20, CharHori=Hori, CharVori=Vori.
- clear asserted mid-stream during a handshake: the byte is dropped, CLEAR runs for 64 cycles, and the cursor is (0,0).
- With TEXT_GRID_SCROLL_EN: fill 4 rows, then send 8'h0A. busy is high for 64 cycles; row 0 holds the old row 1, row 3 is blank, and the cursor is (3,0).

Source files
------------

// File: rtl/text_grid_pkg.sv
// text_grid_pkg: shared state encoding and character constants for the text-grid controller.
package text_grid_pkg;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        SCROLL = 2'd2
    } state_t;

    localparam int         CHAR_W      = 8;
    localparam logic [7:0] CH_SPACE    = 8'h20;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

endpackage

// File: rtl/text_grid_ram.sv
// text_grid_ram: DEPTH x CHAR_W character store, one synchronous write and one synchronous read port.
// A read and a write of the same address in one cycle returns the previous contents.
module text_grid_ram
    import text_grid_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [CHAR_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [CHAR_W-1:0] rdata
);

    logic [CHAR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_grid_ctrl.sv
// text_grid_ctrl: ROWS x COLS text buffer with a cursor-driven byte writer and a per-pixel lookup port.
// Define TEXT_GRID_SCROLL_EN to scroll the buffer up instead of wrapping the cursor back to row 0.
module text_grid_ctrl
    import text_grid_pkg::*;
#(
    parameter int COLS  = 16,
    parameter int ROWS  = 4,
    parameter int PITCH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    input  logic [7:0]              wr_char,
    output logic                    wr_ready,
    input  logic                    clear,
    input  logic [11:0]             Hpos,
    input  logic [11:0]             Vpos,
    input  logic [11:0]             Hori,
    input  logic [11:0]             Vori,
    input  logic [11:0]             size,
    output logic [7:0]              AsciiCode,
    output logic [11:0]             CharHori,
    output logic [11:0]             CharVori,
    output logic                    busy,
    output logic [$clog2(COLS)-1:0] cur_col,
    output logic [$clog2(ROWS)-1:0] cur_row
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int CELLS = ROWS * COLS;
    localparam int AW    = $clog2(CELLS);

    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(CELLS - 1);
`ifdef TEXT_GRID_SCROLL_EN
    // Cursor parks on the last row while the rows above are shifted up.
    localparam logic [RW-1:0] ROW_WRAP  = ROW_LAST;
    localparam logic [AW-1:0] COPY_END  = AW'(COLS * (ROWS - 1));
`else
    localparam logic [RW-1:0] ROW_WRAP  = '0;
`endif

    state_t            state, state_nx;
    logic [AW-1:0]     cnt, cnt_nx;
    logic              accept, take;
    logic              is_print, is_lf, is_bs, row_adv;
    logic [RW-1:0]     row_next;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [CHAR_W-1:0] wdata;
    logic [AW-1:0]     look_addr;
    logic [CHAR_W-1:0] look_q;
`ifdef TEXT_GRID_SCROLL_EN
    logic              row_ovf;
    logic [AW-1:0]     shadow_addr;
    logic [CHAR_W-1:0] shadow_q;
`endif

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return AW'(r) * AW'(COLS) + AW'(c);
    endfunction

    // Byte decode; a clear in the same cycle swallows the accepted byte.
    always_comb begin
        accept   = wr_valid && wr_ready;
        take     = accept && !clear;
        is_print = (wr_char >= CH_PRINT_LO) && (wr_char <= CH_PRINT_HI);
        is_lf    = (wr_char == CH_LF);
        is_bs    = (wr_char == CH_BS) && (cur_col != '0);
        row_adv  = is_lf || (is_print && (cur_col == COL_LAST));
        row_next = (cur_row == ROW_LAST) ? ROW_WRAP : cur_row + 1'b1;
`ifdef TEXT_GRID_SCROLL_EN
        row_ovf  = take && row_adv && (cur_row == ROW_LAST);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            CLEAR, SCROLL: begin
                if (cnt == ADDR_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            IDLE: begin
`ifdef TEXT_GRID_SCROLL_EN
                if (row_ovf) begin
                    state_nx = SCROLL;
                end
`endif
                cnt_nx = '0;
            end
            default: begin
                state_nx = CLEAR;
                cnt_nx   = '0;
            end
        endcase
        if (clear) begin
            state_nx = CLEAR;
            cnt_nx   = '0;
        end
    end

    always_comb begin
        wr_ready = (state == IDLE);
        busy     = (state != IDLE);
        we       = 1'b0;
        waddr    = cnt;
        wdata    = CH_SPACE;
        case (state)
            CLEAR: we = 1'b1;
            IDLE: begin
                if (take && is_print) begin
                    we    = 1'b1;
                    waddr = cell_addr(cur_row, cur_col);
                    wdata = wr_char;
                end else if (take && is_bs) begin
                    we    = 1'b1;
                    waddr = cell_addr(cur_row, cur_col - 1'b1);
                end
            end
`ifdef TEXT_GRID_SCROLL_EN
            SCROLL: begin
                we = 1'b1;
                if (cnt < COPY_END) begin
                    wdata = shadow_q;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear || (state == CLEAR)) begin
            cur_col <= '0;
            cur_row <= '0;
        end else if (take) begin
            if (row_adv) begin
                cur_col <= '0;
                cur_row <= row_next;
            end else if (is_print) begin
                cur_col <= cur_col + 1'b1;
            end else if (is_bs) begin
                cur_col <= cur_col - 1'b1;
            end
        end
    end

    text_grid_ram #(.DEPTH(CELLS), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (look_addr),
        .rdata (look_q)
    );

`ifdef TEXT_GRID_SCROLL_EN
    // Replica of the buffer gives the scroll copy its own read port; the read leads the write by one cycle.
    assign shadow_addr = cnt_nx + AW'(COLS);

    text_grid_ram #(.DEPTH(CELLS), .AW(AW)) u_shadow (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (shadow_addr),
        .rdata (shadow_q)
    );
`endif

    // Lookup stage p0: cell coordinates from the pixel position
    logic [11:0] cw, dx, dy, col_p0, row_p0;
    logic        hin, vin, inside_p0;

    always_comb begin
        cw        = 12'(PITCH) * size;
        hin       = (Hpos >= Hori);
        vin       = (Vpos >= Vori);
        dx        = hin ? (Hpos - Hori) : '0;
        dy        = vin ? (Vpos - Vori) : '0;
        col_p0    = (cw != '0) ? (dx / cw) : '0;
        row_p0    = (cw != '0) ? (dy / cw) : '0;
        inside_p0 = hin && vin && (size != '0) && (cw != '0) &&
                    (col_p0 < 12'(COLS)) && (row_p0 < 12'(ROWS));
        look_addr = AW'(row_p0 * 12'(COLS) + col_p0);
    end

    // Lookup stage p1: registered cell origin alongside the RAM read
    logic inside_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            inside_p1 <= 1'b0;
            CharHori  <= '0;
            CharVori  <= '0;
        end else begin
            inside_p1 <= inside_p0;
            CharHori  <= inside_p0 ? (Hori + col_p0 * cw) : Hori;
            CharVori  <= inside_p0 ? (Vori + row_p0 * cw) : Vori;
        end
    end

    assign AsciiCode = inside_p1 ? look_q : CH_SPACE;

endmodule
